// File: rtl/mux_arb_n.sv
// mux_arb_n: registered N-to-1 channel multiplexer with fixed-select and
// round-robin arbitration, feeding a single-entry output register.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   mode       0 = fixed select (sel), 1 = round-robin
//   sel        channel index used in fixed-select mode
//   in_data    channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high
//   out_data   registered data of the last accepted beat
//   out_ch     channel that supplied out_data
//   out_valid  output beat valid
//   out_ready  downstream accept
//
// Handshake: a beat moves on a rising edge where valid && ready are both high
// on the same side. Producers hold in_valid/in_data until they see in_ready;
// out_valid/out_data/out_ch stay stable until out_ready is seen. in_ready may
// depend combinationally on out_ready, never the other way round.
module mux_arb_n #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int PAD_W = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0] rr_ptr;
    logic [PAD_W-1:0] valid_pad;
    logic             accept;
    logic             fix_valid;
    logic             rr_found;
    logic [SEL_W-1:0] rr_grant;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic             in_xfer;

    // Zero-extending in_valid to a full power-of-two vector makes every sel
    // value a legal index; unused channel slots read as "not valid", which is
    // exactly the "no grant for sel >= NUM_CH" behaviour.
    assign valid_pad = PAD_W'(in_valid);
    assign fix_valid = valid_pad[sel];

    assign accept = !out_valid || out_ready;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        int unsigned idx;
        rr_found = 1'b0;
        rr_grant = '0;
        idx      = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!rr_found && in_valid[idx]) begin
                rr_found = 1'b1;
                rr_grant = SEL_W'(idx);
            end
        end
    end

    assign grant       = mode ? rr_grant : sel;
    assign grant_valid = mode ? rr_found : fix_valid;
    assign in_xfer     = accept && grant_valid;

    // rst gates ready so no producer believes a beat was taken during reset.
    always_comb begin
        in_ready = '0;
        if (in_xfer && !rst) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (in_xfer) begin
                // Covers the simultaneous in/out transfer: new beat replaces old.
                out_valid <= 1'b1;
                out_data  <= in_data[grant*WIDTH +: WIDTH];
                out_ch    <= grant;
                if (mode) begin
                    rr_ptr <= (grant == LAST_CH) ? '0 : grant + 1'b1;
                end
            end else if (out_ready) begin
                // Output drained with nothing to replace it; data/ch are held.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
module tb_mux_arb_n;

    // Instance a: 8 channels x 8 bits. Instance b: 5 channels x 16 bits.
    logic        clk = 1'b0;
    logic        rst;

    logic        a_mode, a_out_ready, a_out_valid;
    logic [2:0]  a_sel, a_out_ch;
    logic [63:0] a_in_data;
    logic [7:0]  a_in_valid, a_in_ready, a_out_data;

    logic        b_mode, b_out_ready, b_out_valid;
    logic [2:0]  b_sel, b_out_ch;
    logic [79:0] b_in_data;
    logic [4:0]  b_in_valid, b_in_ready;
    logic [15:0] b_out_data;

    int checks = 0;
    int errors = 0;

    // reference state: index 0 = instance a, 1 = instance b
    int          nch[2] = '{8, 5};
    bit          m_valid[2];
    logic [15:0] m_data[2];
    int          m_ch[2];
    int          m_ptr[2];

    always #5 clk = ~clk;

    mux_arb_n #(.NUM_CH(8), .WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .mode(a_mode), .sel(a_sel),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid),
        .out_ready(a_out_ready)
    );

    mux_arb_n #(.NUM_CH(5), .WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .mode(b_mode), .sel(b_sel),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Grant by the plain rules: fixed index if legal and valid, otherwise
    // the first valid channel at or after the pointer, going round the ring.
    function automatic int ref_grant(input int k, input logic mode, input int sel,
                                     input logic [7:0] valid);
        int c;
        if (!mode) begin
            if (sel < nch[k] && valid[sel]) return sel;
            return -1;
        end
        for (int j = 0; j < nch[k]; j++) begin
            c = (m_ptr[k] + j) % nch[k];
            if (valid[c]) return c;
        end
        return -1;
    endfunction

    // g >= 0 means an input transfer will happen at the next edge.
    task automatic model_comb(input int k, input logic mode, input int sel,
                              input logic [7:0] valid, input logic ordy,
                              output int g, output logic [7:0] exp_rdy);
        bit acc;
        acc = !m_valid[k] || ordy;
        g = ref_grant(k, mode, sel, valid);
        if (!acc) g = -1;
        exp_rdy = (g >= 0) ? 8'(1 << g) : 8'h00;
    endtask

    task automatic model_seq(input int k, input int g, input logic mode,
                             input logic [15:0] data, input logic ordy);
        if (g >= 0) begin
            m_valid[k] = 1'b1;
            m_data[k]  = data;
            m_ch[k]    = g;
            if (mode) m_ptr[k] = (g + 1) % nch[k];
        end else if (m_valid[k] && ordy) begin
            m_valid[k] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
            m_ch[k]    = 0;
            m_ptr[k]   = 0;
        end
    endtask

    task automatic check_outputs();
        check("a_out_valid", 32'(a_out_valid), 32'(m_valid[0]));
        check("a_out_data",  32'(a_out_data),  32'(m_data[0]));
        check("a_out_ch",    32'(a_out_ch),    32'(m_ch[0]));
        check("a_rr_ptr",    32'(dut_a.rr_ptr), 32'(m_ptr[0]));
        check("b_out_valid", 32'(b_out_valid), 32'(m_valid[1]));
        check("b_out_data",  32'(b_out_data),  32'(m_data[1]));
        check("b_out_ch",    32'(b_out_ch),    32'(m_ch[1]));
        check("b_rr_ptr",    32'(dut_b.rr_ptr), 32'(m_ptr[1]));
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        int ga, gb;
        logic [7:0] ra, rb;
        logic [15:0] da, db;
        #1;
        model_comb(0, a_mode, int'(a_sel), a_in_valid, a_out_ready, ga, ra);
        model_comb(1, b_mode, int'(b_sel), {3'b000, b_in_valid}, b_out_ready, gb, rb);
        check("a_in_ready", 32'(a_in_ready), 32'(ra));
        check("b_in_ready", 32'(b_in_ready), 32'(rb[4:0]));
        da = '0;
        db = '0;
        if (ga >= 0) da = 16'(a_in_data[ga*8 +: 8]);
        if (gb >= 0) db = b_in_data[gb*16 +: 16];
        @(posedge clk);
        model_seq(0, ga, a_mode, da, a_out_ready);
        model_seq(1, gb, b_mode, db, b_out_ready);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle with a busy input side.
    task automatic do_reset();
        a_in_valid = '1; a_mode = 1'b1; a_out_ready = 1'b1;
        b_in_valid = '1; b_mode = 1'b1; b_out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("a_in_ready_rst", 32'(a_in_ready), 32'h0);
        check("b_in_ready_rst", 32'(b_in_ready), 32'h0);
        @(posedge clk);
        #1;
        check("a_in_ready_rst2", 32'(a_in_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic randomize_inputs();
        a_mode      = 1'($urandom_range(0, 1));
        a_sel       = 3'($urandom_range(0, 7));
        a_in_valid  = 8'($urandom);
        a_out_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 8; i++) a_in_data[i*8 +: 8] = 8'($urandom);
        b_mode      = 1'($urandom_range(0, 1));
        b_sel       = 3'($urandom_range(0, 7));
        b_in_valid  = 5'($urandom);
        b_out_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 5; i++) b_in_data[i*16 +: 16] = 16'($urandom);
    endtask

    initial begin
        logic [2:0] exp_ch[3];
        logic [2:0] exp_ptr[3];

        // clock/reset
        rst = 1'b1;
        a_mode = 1'b0; a_sel = '0; a_in_data = '0; a_in_valid = '0; a_out_ready = 1'b0;
        b_mode = 1'b0; b_sel = '0; b_in_data = '0; b_in_valid = '0; b_out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // idle: nothing valid, nothing granted
        repeat (2) cycle();
        check("idle_out_valid", 32'(a_out_valid), 32'h0);

        // round-robin fairness, all channels valid
        a_mode = 1'b1; a_in_valid = 8'hFF; a_out_ready = 1'b1;
        b_mode = 1'b1; b_in_valid = 5'h1F; b_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) a_in_data[i*8 +: 8] = 8'(i);
        for (int i = 0; i < 5; i++) b_in_data[i*16 +: 16] = 16'(16'h1000 + i);
        for (int i = 0; i < 9; i++) begin
            cycle();
            check("rr8_ch",    32'(a_out_ch),    32'(i % 8));
            check("rr8_data",  32'(a_out_data),  32'(i % 8));
            check("rr8_valid", 32'(a_out_valid), 32'h1);
            check("rr5_ch",    32'(b_out_ch),    32'(i % 5));
            check("rr5_ptr_lt5", 32'(dut_b.rr_ptr < 3'd5), 32'h1);
        end

        // move the pointer to 6, then sparse valid 0000_0101 wraps 0,2,0
        a_in_valid = 8'h20;
        cycle();
        check("ptr_at_6", 32'(dut_a.rr_ptr), 32'h6);
        a_in_valid = 8'h05;
        exp_ch  = '{3'd0, 3'd2, 3'd0};
        exp_ptr = '{3'd1, 3'd3, 3'd1};
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("sparse_ch",  32'(a_out_ch),     32'(exp_ch[i]));
            check("sparse_ptr", 32'(dut_a.rr_ptr), 32'(exp_ptr[i]));
        end

        // fixed select sel=5 on a; out-of-range selects on b
        a_mode = 1'b0; a_sel = 3'd5; a_in_valid = 8'hFF; a_in_data[5*8 +: 8] = 8'hA5;
        b_mode = 1'b0; b_sel = 3'd7; b_in_valid = 5'h1F;
        #1;
        check("fix_in_ready", 32'(a_in_ready), 32'h20);
        check("oor7_in_ready", 32'(b_in_ready), 32'h0);
        cycle();
        check("fix_data",  32'(a_out_data),  32'hA5);
        check("fix_ch",    32'(a_out_ch),    32'h5);
        check("fix_valid", 32'(a_out_valid), 32'h1);
        b_sel = 3'd5;
        cycle();
        check("oor5_in_ready", 32'(b_in_ready), 32'h0);

        // back-pressure on a holding ch3 = 3C
        a_sel = 3'd3; a_in_data[3*8 +: 8] = 8'h3C;
        cycle();
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("bp_in_ready", 32'(a_in_ready),  32'h0);
            check("bp_data",     32'(a_out_data),  32'h3C);
            check("bp_ch",       32'(a_out_ch),    32'h3);
            check("bp_valid",    32'(a_out_valid), 32'h1);
        end
        a_out_ready = 1'b1; a_sel = 3'd6; a_in_data[6*8 +: 8] = 8'h66;
        cycle();
        check("bp_release_valid", 32'(a_out_valid), 32'h1);
        check("bp_release_data",  32'(a_out_data),  32'h66);
        check("bp_release_ch",    32'(a_out_ch),    32'h6);

        // reset while holding a beat
        do_reset();
        a_in_valid = '0; b_in_valid = '0;
        cycle();
        check("post_rst_valid", 32'(a_out_valid), 32'h0);

        // random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end
            randomize_inputs();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised, registered N-to-1 channel multiplexer. It is the next generation of the team's 8:1 combinational mux.
- Each input channel carries WIDTH-bit data with a valid/ready handshake.
- Two selection modes:
  - fixed select: behaves like the existing mux, with the selected channel chosen by a select input.
  - round-robin: fair arbitration across all valid channels.
- Sits between multiple producers and a single downstream consumer. It provides a one-beat registered output stage.

Parameters:
- NUM_CH, 8, number of input channels (>=2).
- WIDTH, 8, data width per channel.
- SEL_W, $clog2(NUM_CH), width of the select and channel-ID fields; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; at most one bit high.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async assert, sync release on the next clk edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
- Output register has capacity 1.
  - accept = !out_valid || out_ready (combinational).
- Grant logic is combinational:
  - mode=0: grant = sel when sel < NUM_CH and in_valid[sel]=1. Otherwise no grant.
  - When sel >= NUM_CH there is never a grant, and in_ready is all zero.
  - mode=1: grant = first index i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_CH. No grant if in_valid is all zero.
- Handshakes:
  - in_ready[i] = accept && grant_valid && (grant==i). All other in_ready bits are 0.
  - An input transfer occurs when in_valid[i] && in_ready[i].
  - On that clk edge: out_data <= channel data, out_ch <= i, out_valid <= 1.
  - Latency is 1 cycle, input transfer to out_valid.
- Output transfer occurs when out_valid && out_ready.
  - If no input transfer happens in the same cycle, out_valid <= 0.
  - out_data and out_ch are held (not cleared).
- Simultaneous output and input transfer: the new beat replaces the old one, out_valid stays 1. This gives full throughput of 1 beat/cycle.
- Back-pressure: while out_valid=1 && out_ready=0, out_data, out_ch and out_valid are stable and all in_ready=0.
- rr_ptr (SEL_W bits):
  - On an input transfer with mode=1: rr_ptr <= (grant+1) mod NUM_CH. Wraps from NUM_CH-1 to 0, including non-power-of-2 NUM_CH.
  - With mode=0, rr_ptr is unchanged.
- A mode or sel change takes effect in the same cycle, combinationally. A beat already held in the output register is unaffected.
- Reset mid-operation: a held beat is discarded (out_valid=0 immediately). No in_ready is asserted while rst=1.
- No combinational path from in_data to out_data. There is a combinational path from out_ready to in_ready; this is permitted.

Test Plan:
- Reset/idle: assert rst with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately. With in_valid=0 after release, in_ready=0 and out_valid stays 0.
- Fixed select: mode=0, sel=5, in_valid=8'hFF, ch5 data=8'hA5, out_ready=1 -> in_ready=8'h20. Next cycle out_data=8'hA5, out_ch=5, out_valid=1. Then set sel=9 with NUM_CH=10 and in_valid[9]=0 -> in_ready=0.
- Round-robin fairness: mode=1, in_valid=8'hFF held, out_ready=1, channel i data=i -> out_ch sequence 0,1,2,...,7,0 on consecutive cycles. out_valid stays 1 continuously.
- Sparse round-robin with wrap: rr_ptr=6, in_valid=8'b0000_0101 -> grants ch0 then ch2, then ch0 again. rr_ptr values 1, 3, 1.
- Back-pressure: out_valid=1 holding ch3 data 8'h3C, out_ready=0 for 4 cycles, all in_valid=1 -> in_ready=0, out_data=8'h3C, out_ch=3 stable. When out_ready=1, the next beat loads on that edge with no bubble.
- Non-power-of-2: NUM_CH=5, WIDTH=16, mode=1, all valid -> out_ch cycles 0..4 then back to 0. rr_ptr never reaches 5..7.
